// File: rtl/automata_stage_gen_if.sv
// Report-port bundle for automata_stage_gen: FIFO head valid/ready, head entry and occupancy.
interface automata_stage_gen_if #(
  parameter int CNT_W = 32,
  parameter int N_RPT = 40,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic                   rpt_valid;
  logic                   rpt_ready;
  logic [CNT_W+N_RPT-1:0] rpt_data;
  logic [LW-1:0]          rpt_level;

  modport master (output rpt_valid, rpt_data, rpt_level, input rpt_ready);
  modport slave  (input rpt_valid, rpt_data, rpt_level, output rpt_ready);
endinterface

// File: rtl/automata_stage_gen.sv
// Automata stage glue: symbol/reset forwarding pipes, symbol counter and report FIFO.
// Optional report accumulator enabled by defining REPORT_STICKY_EN.
module automata_stage_gen #(
  parameter int SYM_W = 8,
  parameter int N_RPT = 40,
  parameter int PIPE  = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [SYM_W-1:0]     top_symbols,
  input  logic [N_RPT-1:0]     report_in,
  output logic [SYM_W-1:0]     out_symbols,
  output logic                 out_reset,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic [N_RPT-1:0]     rpt_sticky,
  input  logic                 sticky_clr,
  automata_stage_gen_if.master rpt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int DW = CNT_W + N_RPT;

  logic [PIPE-1:0][SYM_W-1:0] sym_pipe;
  logic [PIPE-1:0]            rst_pipe;
  logic [CNT_W-1:0]           sym_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_pipe <= '0;
    end else if (run) begin
      sym_pipe[0] <= top_symbols;
      for (int i = 1; i < PIPE; i++) sym_pipe[i] <= sym_pipe[i-1];
    end
  end

  // Ones drain out one stage per edge once reset drops, stretching out_reset by PIPE edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_pipe <= '1;
    end else begin
      rst_pipe[0] <= 1'b0;
      for (int i = 1; i < PIPE; i++) rst_pipe[i] <= rst_pipe[i-1];
    end
  end

  assign out_symbols = sym_pipe[PIPE-1];
  assign out_reset   = rst_pipe[PIPE-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    sym_cnt <= '0;
    else if (run) sym_cnt <= sym_cnt + 1'b1;
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic          push, pop, full, wr;

  assign push = run & (|report_in);
  assign pop  = rpt.rpt_valid & rpt.rpt_ready;
  assign full = (level == LW'(DEPTH));
  // When full, a concurrent pop frees the head slot, which is exactly where wptr points.
  assign wr   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {sym_cnt, report_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + LW'(wr) - LW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   ovf <= 1'b0;
    else if (push & full & ~pop) ovf <= 1'b1;
    else if (ovf_clr)            ovf <= 1'b0;
  end

  assign rpt.rpt_valid = (level != '0);
  assign rpt.rpt_level = level;
  assign rpt.rpt_data  = mem[rptr];

`ifdef REPORT_STICKY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rpt_sticky <= '0;
    else       rpt_sticky <= (sticky_clr ? '0 : rpt_sticky) | (run ? report_in : '0);
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign rpt_sticky        = '0;
`endif
endmodule

// File: tb/tb_automata_stage_gen.sv
// Randomized bench for automata_stage_gen with a queue-based reference model and directed pins.
module tb_automata_stage_gen;
  localparam int SYM_W = 8, N_RPT = 40, PIPE = 2, DEPTH = 8, CNT_W = 32;
  localparam int DW = CNT_W + N_RPT;

  logic clk = 1'b0, reset = 1'b0, run = 1'b0, ovf_clr = 1'b0, sticky_clr = 1'b0;
  logic [SYM_W-1:0] top_symbols = '0;
  logic [N_RPT-1:0] report_in = '0;
  logic [SYM_W-1:0] out_symbols;
  logic             out_reset, ovf;
  logic [N_RPT-1:0] rpt_sticky;

  automata_stage_gen_if #(.CNT_W(CNT_W), .N_RPT(N_RPT), .DEPTH(DEPTH)) rif ();

  automata_stage_gen #(.SYM_W(SYM_W), .N_RPT(N_RPT), .PIPE(PIPE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .top_symbols(top_symbols), .report_in(report_in),
    .out_symbols(out_symbols), .out_reset(out_reset), .ovf(ovf), .ovf_clr(ovf_clr),
    .rpt_sticky(rpt_sticky), .sticky_clr(sticky_clr), .rpt(rif.master)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue of entries, symbol delay line as a queue of PIPE values.
  logic [DW-1:0]    mq[$];
  logic [SYM_W-1:0] symq[$];
  bit [CNT_W-1:0]   m_cnt;
  bit               m_ovf, m_pop, m_push, m_drop;
  logic [N_RPT-1:0] m_sticky;
  int               m_since;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      symq.delete();
      for (int i = 0; i < PIPE; i++) symq.push_back('0);
      m_cnt = '0; m_ovf = 0; m_sticky = '0; m_since = 0;
    end else begin
      m_pop  = (mq.size() > 0) && rif.rpt_ready;
      m_push = run && (report_in != '0);
      m_drop = 0;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back({m_cnt, report_in});
        else m_drop = 1;
      end
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
`ifdef REPORT_STICKY_EN
      if (sticky_clr) m_sticky = '0;
      if (run) m_sticky = m_sticky | report_in;
`endif
      if (run) begin
        symq.push_front(top_symbols);
        void'(symq.pop_back());
        m_cnt = m_cnt + 1;
      end
      if (m_since < PIPE) m_since++;
    end
  end

  always @(negedge clk) begin
    if (symq.size() == PIPE) begin
      chk("rpt_valid", rif.rpt_valid, mq.size() != 0);
      chk("rpt_level", rif.rpt_level, mq.size());
      if (mq.size() != 0) chk("rpt_data", rif.rpt_data, mq[0]);
      chk("ovf", ovf, m_ovf);
      chk("out_symbols", out_symbols, symq[PIPE-1]);
      chk("out_reset", out_reset, reset || (m_since < PIPE));
      chk("rpt_sticky", rpt_sticky, m_sticky);
    end
  end

  task automatic cyc(input logic r, input logic [SYM_W-1:0] s, input logic [N_RPT-1:0] rp, input logic rdy);
    run = r; top_symbols = s; report_in = rp; rif.rpt_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    run = 0; report_in = '0; rif.rpt_ready = 0;
    reset = 1; @(posedge clk); #1; reset = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [N_RPT-1:0] rp;
    rif.rpt_ready = 0;
    #1 reset = 1;
    repeat (2) @(posedge clk); #1;
    chk("reset_valid", rif.rpt_valid, 0);
    chk("reset_level", rif.rpt_level, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_sym", out_symbols, 0);
    chk("reset_outrst", out_reset, 1);
    chk("reset_sticky", rpt_sticky, 0);
    reset = 0;

    // Symbol pipe depth 2 and freeze on run=0; reset stretch over 2 edges.
    cyc(1, 8'h11, '0, 0);
    chk("outrst_edge1", out_reset, 1);
    cyc(1, 8'h22, '0, 0);
    chk("outrst_edge2", out_reset, 0);
    chk("pipe_2edges", out_symbols, 8'h11);
    cyc(1, 8'h33, '0, 0);
    chk("pipe_next", out_symbols, 8'h22);
    repeat (3) cyc(0, 8'h44, '0, 0);
    chk("pipe_frozen", out_symbols, 8'h22);

    // Counter has reached 3; two more run edges make it 5.
    cyc(1, 8'h00, '0, 0);
    cyc(1, 8'h00, '0, 0);
    cyc(1, 8'h55, 40'h1, 0);
    chk("push5_data", rif.rpt_data, {32'd5, 40'h1});
    chk("push5_valid", rif.rpt_valid, 1);
    chk("push5_level", rif.rpt_level, 1);

    // Overflow after 9 pushes, then in-order drain of the first 8.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 8'(i), N_RPT'(i + 1), 0);
    chk("ovf_level", rif.rpt_level, 8);
    chk("ovf_set", ovf, 1);
    for (int j = 0; j < 8; j++) begin
      chk("drain_order", rif.rpt_data, {32'(j), N_RPT'(j + 1)});
      cyc(0, 8'h00, '0, 1);
    end
    chk("drain_empty", rif.rpt_valid, 0);
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1; cyc(0, 8'h00, '0, 0); ovf_clr = 0;
    chk("ovf_clr", ovf, 0);

    // Full FIFO with push+pop, then set-beats-clear on a real overflow.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 8'h00, N_RPT'(8'h10 + i), 0);
    cyc(1, 8'h00, 40'hAA, 1);
    chk("fullpp_level", rif.rpt_level, 8);
    chk("fullpp_ovf", ovf, 0);
    ovf_clr = 1; cyc(1, 8'h00, 40'hBB, 0); ovf_clr = 0;
    chk("ovf_setwins", ovf, 1);
    chk("ovf_level8", rif.rpt_level, 8);
    for (int k = 0; k < 8; k++) begin
      if (k < 7) chk("fullpp_order", rif.rpt_data, {32'(k + 1), N_RPT'(8'h11 + k)});
      else       chk("fullpp_last", rif.rpt_data, {32'd8, 40'hAA});
      cyc(0, 8'h00, '0, 1);
    end

    // Asynchronous flush of queued entries.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 8'(i), N_RPT'(i + 3), 0);
    chk("pre_flush_level", rif.rpt_level, 5);
    reset = 1; #1;
    chk("async_valid", rif.rpt_valid, 0);
    chk("async_level", rif.rpt_level, 0);
    chk("async_outrst", out_reset, 1);
    @(posedge clk); #1; reset = 0;
    cyc(0, 8'h00, '0, 0);
    chk("rel_edge1", out_reset, 1);
    cyc(0, 8'h00, '0, 0);
    chk("rel_edge2", out_reset, 0);

`ifdef REPORT_STICKY_EN
    do_reset();
    cyc(1, 8'h00, 40'h8, 1);
    chk("sticky_set", rpt_sticky[3], 1);
    cyc(1, 8'h00, '0, 1);
    chk("sticky_hold", rpt_sticky[3], 1);
    sticky_clr = 1; cyc(1, 8'h00, 40'h8, 1); sticky_clr = 0;
    chk("sticky_setwins", rpt_sticky[3], 1);
    sticky_clr = 1; cyc(1, 8'h00, '0, 1); sticky_clr = 0;
    chk("sticky_clr", rpt_sticky[3], 0);
`else
    sticky_clr = 1; cyc(1, 8'h00, 40'h8, 1); sticky_clr = 0;
    chk("sticky_off", rpt_sticky, 0);
`endif

    // Random traffic with phases of slow and fast draining.
    for (int n = 0; n < 3000; n++) begin
      int rdy_pct;
      rdy_pct = ((n / 200) % 3 == 0) ? 15 : ((n / 200) % 3 == 1) ? 50 : 90;
      rp = '0;
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) rp = N_RPT'(1) << $urandom_range(0, N_RPT - 1);
        else                           rp = N_RPT'({$urandom(), $urandom()});
      end
      ovf_clr    = ($urandom_range(0, 15) == 0);
      sticky_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) reset = 1;
      cyc($urandom_range(0, 3) != 0, 8'($urandom()), rp, $urandom_range(0, 99) < rdy_pct);
      reset = 0;
    end
    ovf_clr = 0; sticky_clr = 0;
    cyc(0, 8'h00, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/automata_stage_gen.md
AUTOMATA_STAGE_GEN -- requirements
Module: automata_stage_gen

Interface
REQ-001 Parameter SYM_W, default 8, symbol width in bits.
REQ-002 Parameter N_RPT, default 40, number of report bits collected from the stage's automata.
REQ-003 Parameter PIPE, default 1, symbol/reset forwarding depth in registers, legal range 1..4.
REQ-004 Parameter DEPTH, default 8, report FIFO entries, power of two, at least 2.
REQ-005 Parameter CNT_W, default 32, symbol-counter width.
REQ-006 clk  in  1  single clock; all flops use the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 run  in  1  stream-enable qualifier for the symbol and report paths.
REQ-009 top_symbols  in  SYM_W  input symbol stream.
REQ-010 report_in  in  N_RPT  report bits of the current symbol, bit i = report i.
REQ-011 out_symbols  out  SYM_W  forwarded symbol to the next stage.
REQ-012 out_reset  out  1  forwarded reset to the next stage.
REQ-013 rpt_valid  out  1  FIFO head valid.
REQ-014 rpt_ready  in  1  consumer accepts head.
REQ-015 rpt_data  out  CNT_W+N_RPT  head entry, {symbol index, report vector}.
REQ-016 rpt_level  out  clog2(DEPTH+1)  current FIFO occupancy.
REQ-017 ovf  out  1  sticky overflow flag.
REQ-018 ovf_clr  in  1  clears ovf.
REQ-019 rpt_sticky  out  N_RPT  accumulated report bits.
REQ-020 sticky_clr  in  1  clears rpt_sticky.

Function
REQ-021 Symbol pipe: PIPE registers in series; each advances only on an edge with run=1; out_symbols = last register.
REQ-022 Reset pipe: PIPE registers in series, advancing every edge regardless of run; out_reset = 1 while reset is high and for exactly PIPE edges after deassertion.
REQ-023 sym_cnt (internal, CNT_W): increments on each edge with run=1; wraps from all-ones to 0.
REQ-024 Push: on an edge with run=1 and report_in nonzero, write {sym_cnt pre-increment value, report_in}.
REQ-025 Nothing is pushed when run=0 or report_in=0.
REQ-026 Pop: occurs on an edge with rpt_valid=1 and rpt_ready=1; rpt_ready with rpt_valid=0 has no effect.
REQ-027 rpt_valid = (rpt_level != 0); rpt_data is the oldest entry, held stable until popped.
REQ-028 FIFO order is strictly first-in first-out; pointers wrap modulo DEPTH.
REQ-029 Simultaneous push and pop at any level, full included: both occur, level unchanged, no overflow.
REQ-030 Push when full without pop: entry dropped, FIFO contents unchanged, ovf set to 1 on that edge.
REQ-031 Push and pop when empty: the new entry is stored, and rpt_valid is asserted on the next cycle.
REQ-032 ovf_clr on the same edge as an overflow event: set wins, ovf stays 1.
REQ-033 Latency: a push at edge N gives rpt_valid=1 after edge N if the FIFO was empty.

Reset
REQ-034 Reset asserted: symbol pipe = 0, sym_cnt = 0, FIFO empty (rpt_valid=0, rpt_level=0), ovf=0, rpt_sticky=0, out_symbols=0, out_reset=1.
REQ-035 Reset asserted mid-operation discards all queued entries immediately, with no clock edge required.

Configuration
REQ-036 Macro REPORT_STICKY_EN defined: rpt_sticky[i] is set on any edge with run=1 and report_in[i]=1, and cleared by sticky_clr; set wins over a simultaneous clear.
REQ-037 Macro REPORT_STICKY_EN undefined: rpt_sticky is constant 0, sticky_clr is ignored, and no accumulator flops exist.

Verification
REQ-038 PIPE=2, run=1, symbols 0x11,0x22,0x33 -> out_symbols shows 0x11 two edges after input; run=0 for 3 cycles -> out_symbols frozen.
REQ-039 report_in=0x1 at sym_cnt=5 with rpt_ready=0 -> rpt_data={5,0x1}, rpt_valid=1, rpt_level=1.
REQ-040 DEPTH=8, 9 reports with rpt_ready=0 -> rpt_level=8, ovf=1, and entries 1..8 pop in order.
REQ-041 Full FIFO, simultaneous push and pop -> level stays 8, ovf=0, and the new entry appears last.
REQ-042 Reset pulse with 5 queued entries -> rpt_valid=0 asynchronously, out_reset=1 for PIPE edges after release.
REQ-043 With REPORT_STICKY_EN: report_in bit 3 pulses once, then sticky_clr together with a new bit-3 pulse -> rpt_sticky[3] stays 1; a clear with no pulse -> rpt_sticky[3]=0.
